// File: rtl/uart_arb_pkg.sv
// Shared types for the UART register-port arbiter: FSM states, master index,
// and the timeout counter width.
package uart_arb_pkg;
  localparam int TIMEOUT_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RESP
  } arb_state_e;

  typedef logic mst_idx_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant; the pointer moves to the loser of each grant
// so a continuously requesting pair alternates.
module rr_arb2
  import uart_arb_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  mst_idx_t prio_q, prio_d;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = (prio_q == 1'b0) ? 2'b01 : 2'b10;
  end

  always_comb begin
    prio_d = prio_q;
    if (advance_i && (gnt_o != 2'b00)) prio_d = gnt_o[0];
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) prio_q <= 1'b0;
    else         prio_q <= prio_d;
  end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Shares the UART register slave port between CPU (m0) and debug loader (m1),
// one transaction at a time, with a stall timeout on the slave ack.
module uart_bus_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [31:0] m0_adr,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [31:0] m1_adr,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack,
  output logic        m1_err,
  output logic        s_stb,
  output logic        s_we,
  output logic [31:0] s_adr,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack,
  output logic [1:0]  gnt
);

  // state     | meaning
  // ARB_IDLE  | no grant; pick a requester
  // ARB_ISSUE | s_stb high for the granted master, wait for ack or timeout
  // ARB_RESP  | s_stb low, ack (and err on timeout) to the granted master

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

  arb_state_e           state_q, state_d;
  logic [1:0]           gnt_q, gnt_d, arb_gnt;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 to_q, to_d;
  logic                 arb_adv;
  logic                 resp;

  rr_arb2 u_rr (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req_i     ({m1_stb, m0_stb}),
    .advance_i (arb_adv),
    .gnt_o     (arb_gnt)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    arb_adv = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (m0_stb || m1_stb) begin
          state_d = ARB_ISSUE;
          gnt_d   = arb_gnt;
          arb_adv = 1'b1;
          cnt_d   = '0;
          to_d    = 1'b0;
        end
      end
      ARB_ISSUE: begin
        if (!s_ack) cnt_d = cnt_q + TIMEOUT_W'(1);
        if (s_ack) begin
          state_d = ARB_RESP;
        end else if (cnt_q == TO_LAST) begin
          state_d = ARB_RESP;
          to_d    = 1'b1;
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
        gnt_d   = 2'b00;
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= 2'b00;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // Slave fields follow the granted master's live signals; zero with no grant.
  always_comb begin
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_o = '0;
    if (gnt_q[0]) begin
      s_we    = m0_we;
      s_adr   = m0_adr;
      s_dat_o = m0_dat_i;
    end else if (gnt_q[1]) begin
      s_we    = m1_we;
      s_adr   = m1_adr;
      s_dat_o = m1_dat_i;
    end
  end

  assign s_stb    = (state_q == ARB_ISSUE);
  assign resp     = (state_q == ARB_RESP);
  assign gnt      = gnt_q;
  assign m0_ack   = resp & gnt_q[0];
  assign m1_ack   = resp & gnt_q[1];
  assign m0_err   = m0_ack & to_q;
  assign m1_err   = m1_ack & to_q;
  assign m0_dat_o = (m0_ack && !to_q) ? s_dat_i : '0;
  assign m1_dat_o = (m1_ack && !to_q) ? s_dat_i : '0;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Bench for uart_bus_arbiter: directed scenarios plus a randomized two-master run
// against a transaction-window model.
module tb_uart_bus_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        m0_stb, m1_stb, m0_we, m1_we;
  logic [31:0] m0_adr, m1_adr, m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
  logic        m0_ack, m1_ack, m0_err, m1_err;
  logic        s_stb, s_we, s_ack;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic [1:0]  gnt;

  int checks = 0;
  int errors = 0;

  int          stall_cfg = 0;
  logic        stuck = 1'b0;
  logic [31:0] rx_base = 32'h0;
  int          stb_run, rx_pops, slv_rd, slv_wr;
  logic [31:0] regs [4];

  always #5 sys_clk = ~sys_clk;

  uart_bus_arbiter #(.TIMEOUT(8)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack(s_ack), .gnt(gnt)
  );

  // Slave: acks after stall_cfg stalled cycles; adr 0 reads pop an RX counter.
  assign s_ack = s_stb && !stuck && (stb_run == stall_cfg);

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      stb_run <= 0; rx_pops <= 0; slv_rd <= 0; slv_wr <= 0; s_dat_i <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      stb_run <= s_stb ? stb_run + 1 : 0;
      if (s_stb && s_ack && s_we) begin
        regs[s_adr[1:0]] <= s_dat_o;
        slv_wr <= slv_wr + 1;
        s_dat_i <= $urandom;
      end else if (s_stb && s_ack) begin
        s_dat_i <= (s_adr[1:0] == 2'd0) ? rx_base + rx_pops : regs[s_adr[1:0]];
        if (s_adr[1:0] == 2'd0) rx_pops <= rx_pops + 1;
        slv_rd <= slv_rd + 1;
      end else begin
        s_dat_i <= $urandom;
      end
    end
  end

  task automatic step;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic apply_reset;
    sys_rst = 1'b1;
    m0_stb = 0; m1_stb = 0; m0_we = 0; m1_we = 0;
    m0_adr = '0; m1_adr = '0; m0_dat_i = '0; m1_dat_i = '0;
    stuck = 1'b0; stall_cfg = 0;
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
  endtask

  task automatic test_reset;
    sys_rst = 1'b1;
    m0_stb = 1; m1_stb = 1; m0_we = 1; m1_we = 1;
    m0_adr = 32'h3; m1_adr = 32'h2; m0_dat_i = 32'hdead; m1_dat_i = 32'hbeef;
    #3;
    checks++; if ({s_stb, s_we, gnt, m0_ack, m1_ack, m0_err, m1_err} !== 8'b0) begin errors++; $display("FAIL reset_ctrl got=%b exp=0", {s_stb, s_we, gnt, m0_ack, m1_ack, m0_err, m1_err}); end
    checks++; if ({m0_dat_o, m1_dat_o, s_adr, s_dat_o} !== 128'b0) begin errors++; $display("FAIL reset_data got=%h exp=0", {m0_dat_o, m1_dat_o, s_adr, s_dat_o}); end
    apply_reset;
    step;
    checks++; if ({s_stb, gnt} !== 3'b0) begin errors++; $display("FAIL idle_after_reset got=%b exp=000", {s_stb, gnt}); end
  endtask

  task automatic test_single_read;
    int nstb = 0;
    apply_reset;
    rx_base = 32'h0000_0141;
    m0_stb = 1; m0_we = 0; m0_adr = 32'h0;
    for (int c = 1; c <= 5; c++) begin
      step;
      if (s_stb) nstb++;
      if (c == 3) m0_stb = 0;
      checks++; if (m0_ack !== (c == 2)) begin errors++; $display("FAIL single_ack c=%0d got=%b exp=%b", c, m0_ack, c == 2); end
      if (c == 2) begin
        checks++; if ({m0_err, m0_dat_o} !== {1'b0, 32'h141}) begin errors++; $display("FAIL single_data got=%b/%h exp=0/141", m0_err, m0_dat_o); end
      end
    end
    checks++; if (nstb !== 1) begin errors++; $display("FAIL single_stb_cycles got=%0d exp=1", nstb); end
  endtask

  task automatic test_contention;
    logic [1:0] eg;
    apply_reset;
    m0_stb = 1; m1_stb = 1; m0_adr = 32'h1; m1_adr = 32'h2;
    for (int c = 1; c <= 12; c++) begin
      step;
      eg = (c % 3 == 0) ? 2'b00 : ((((c - 1) / 3) % 2 == 0) ? 2'b01 : 2'b10);
      checks++; if (gnt !== eg) begin errors++; $display("FAIL contend_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
      checks++; if ({m0_ack, m1_ack} !== {c == 2 || c == 8, c == 5 || c == 11}) begin errors++; $display("FAIL contend_ack c=%0d got=%b%b", c, m0_ack, m1_ack); end
      if (c == 12) begin m0_stb = 0; m1_stb = 0; end
    end
    step;
  endtask

  task automatic test_held_stb;
    apply_reset;
    rx_base = 32'h0000_00a0;
    m1_stb = 1; m1_we = 0; m1_adr = 32'h0;
    for (int c = 1; c <= 7; c++) begin
      step;
      if (c == 4) m1_stb = 0;
      checks++; if (s_stb !== (c == 1 || c == 4)) begin errors++; $display("FAIL held_s_stb c=%0d got=%b", c, s_stb); end
      checks++; if (m1_ack !== (c == 2 || c == 5)) begin errors++; $display("FAIL held_ack c=%0d got=%b", c, m1_ack); end
      if (c == 2 || c == 5) begin
        checks++; if (m1_dat_o !== rx_base + ((c == 5) ? 32'd1 : 32'd0)) begin errors++; $display("FAIL held_data c=%0d got=%h", c, m1_dat_o); end
      end
    end
    checks++; if (slv_rd !== 2) begin errors++; $display("FAIL held_slave_reads got=%0d exp=2", slv_rd); end
  endtask

  task automatic test_stall;
    apply_reset;
    stall_cfg = 5;
    m0_stb = 1; m0_we = 1; m0_adr = 32'h0; m0_dat_i = 32'h55;
    for (int c = 1; c <= 8; c++) begin
      step;
      if (c == 8) m0_stb = 0;
      checks++; if (m0_ack !== (c == 7)) begin errors++; $display("FAIL stall_ack c=%0d got=%b exp=%b", c, m0_ack, c == 7); end
      if (c == 7) begin
        checks++; if (m0_err !== 1'b0) begin errors++; $display("FAIL stall_err got=%b exp=0", m0_err); end
      end
      if (c <= 7) begin
        checks++; if ({s_stb, s_we, s_dat_o} !== {c <= 6, 1'b1, 32'h55}) begin errors++; $display("FAIL stall_slave c=%0d got=%b%b/%h", c, s_stb, s_we, s_dat_o); end
      end
    end
    checks++; if (slv_wr !== 1) begin errors++; $display("FAIL stall_writes got=%0d exp=1", slv_wr); end
    stall_cfg = 0;
  endtask

  task automatic test_timeout;
    int nstb = 0;
    apply_reset;
    stuck = 1'b1;
    m0_stb = 1; m0_we = 0; m0_adr = 32'h2;
    for (int c = 1; c <= 10; c++) begin
      step;
      if (s_stb) nstb++;
      if (c == 10) begin m0_stb = 0; stuck = 1'b0; end
      checks++; if (m0_ack !== (c == 9)) begin errors++; $display("FAIL to_ack c=%0d got=%b exp=%b", c, m0_ack, c == 9); end
      if (c == 9) begin
        checks++; if ({m0_err, m0_dat_o} !== {1'b1, 32'h0}) begin errors++; $display("FAIL to_err_data got=%b/%h exp=1/0", m0_err, m0_dat_o); end
      end
    end
    checks++; if (nstb !== 8) begin errors++; $display("FAIL to_stb_cycles got=%0d exp=8", nstb); end
    rx_base = 32'h777;
    m0_stb = 1; m0_adr = 32'h0;
    for (int c = 1; c <= 3; c++) begin
      step;
      if (c == 3) m0_stb = 0;
      checks++; if (m0_ack !== (c == 2)) begin errors++; $display("FAIL to_recover_ack c=%0d got=%b", c, m0_ack); end
      if (c == 2) begin
        checks++; if ({m0_err, m0_dat_o} !== {1'b0, 32'h777}) begin errors++; $display("FAIL to_recover_data got=%b/%h exp=0/777", m0_err, m0_dat_o); end
      end
    end
  endtask

  task automatic test_reset_mid_issue;
    apply_reset;
    stuck = 1'b1;
    m0_stb = 1; m0_we = 0; m0_adr = 32'h1;
    step; step;
    checks++; if ({s_stb, gnt} !== 3'b101) begin errors++; $display("FAIL rst_pre got=%b exp=101", {s_stb, gnt}); end
    sys_rst = 1'b1; m0_stb = 0;
    #1;
    checks++; if ({s_stb, gnt, m0_ack, m1_ack, m0_err, m1_err} !== 7'b0) begin errors++; $display("FAIL rst_async got=%b exp=0", {s_stb, gnt, m0_ack, m1_ack, m0_err, m1_err}); end
    stuck = 1'b0;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    m0_stb = 1; m1_stb = 1;
    step;
    checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rst_post_gnt got=%b exp=01", gnt); end
    step;
    checks++; if ({m0_ack, m1_ack} !== 2'b10) begin errors++; $display("FAIL rst_post_ack got=%b exp=10", {m0_ack, m1_ack}); end
    m0_stb = 0; m1_stb = 0;
    repeat (3) step;
  endtask

  task automatic test_random;
    int          prio_m, cur, iss_s, iss_e, ack_c, free_c;
    logic        exp_we;
    logic [31:0] exp_adr, exp_wd, exp_rd, exp_rx;
    logic [31:0] mregs [4];
    logic        mstb [2], mwe [2];
    logic [31:0] madr [2], mdat [2];
    bit          acked_prev [2];
    logic [1:0]  eg;
    logic        in_iss;
    apply_reset;
    rx_base = $urandom;
    exp_rx = rx_base;
    prio_m = 0; cur = -1; iss_s = -1; iss_e = -2; ack_c = -1; free_c = 0;
    exp_we = 0; exp_adr = '0; exp_wd = '0; exp_rd = '0;
    for (int i = 0; i < 4; i++) mregs[i] = '0;
    for (int m = 0; m < 2; m++) begin
      mstb[m] = 0; mwe[m] = 0; madr[m] = '0; mdat[m] = '0; acked_prev[m] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      if (c > 0) step;
      in_iss = (c >= iss_s && c <= iss_e);
      eg = (cur >= 0 && c >= iss_s && c <= ack_c) ? ((cur == 0) ? 2'b01 : 2'b10) : 2'b00;
      checks++; if (s_stb !== in_iss) begin errors++; $display("FAIL rnd_s_stb c=%0d got=%b exp=%b", c, s_stb, in_iss); end
      checks++; if (gnt !== eg) begin errors++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, gnt, eg); end
      checks++; if ({m0_ack, m1_ack, m0_err, m1_err} !== {cur == 0 && c == ack_c, cur == 1 && c == ack_c, 2'b00}) begin errors++; $display("FAIL rnd_ack c=%0d got=%b", c, {m0_ack, m1_ack, m0_err, m1_err}); end
      if (in_iss) begin
        checks++; if ({s_we, s_adr, s_dat_o} !== {exp_we, exp_adr, exp_wd}) begin errors++; $display("FAIL rnd_slave c=%0d got=%b/%h/%h exp=%b/%h/%h", c, s_we, s_adr, s_dat_o, exp_we, exp_adr, exp_wd); end
      end
      if (c == ack_c && !exp_we) begin
        checks++; if (((cur == 0) ? m0_dat_o : m1_dat_o) !== exp_rd) begin errors++; $display("FAIL rnd_rdata c=%0d m=%0d got=%h exp=%h", c, cur, (cur == 0) ? m0_dat_o : m1_dat_o, exp_rd); end
      end
      checks++; if ({eg[0] ? 32'h0 : m0_dat_o, eg[1] ? 32'h0 : m1_dat_o} !== 64'h0) begin errors++; $display("FAIL rnd_idle_data c=%0d got=%h/%h", c, m0_dat_o, m1_dat_o); end
      for (int m = 0; m < 2; m++) begin
        if (acked_prev[m]) begin
          acked_prev[m] = 0;
          mstb[m] = ($urandom_range(0, 3) == 0);
        end else if (!mstb[m]) begin
          mstb[m] = ($urandom_range(0, 2) == 0);
        end else begin
          continue;
        end
        if (mstb[m]) begin
          mwe[m] = $urandom_range(0, 1); madr[m] = $urandom; mdat[m] = $urandom;
        end
      end
      if (cur >= 0 && c == ack_c) acked_prev[cur] = 1;
      m0_stb = mstb[0]; m0_we = mwe[0]; m0_adr = madr[0]; m0_dat_i = mdat[0];
      m1_stb = mstb[1]; m1_we = mwe[1]; m1_adr = madr[1]; m1_dat_i = mdat[1];
      if (c >= free_c && (mstb[0] || mstb[1])) begin
        if (mstb[0] && mstb[1]) cur = prio_m;
        else cur = mstb[0] ? 0 : 1;
        prio_m = 1 - cur;
        stall_cfg = $urandom_range(0, 4);
        iss_s = c + 1; iss_e = c + 1 + stall_cfg; ack_c = c + 2 + stall_cfg; free_c = c + 3 + stall_cfg;
        exp_we = mwe[cur]; exp_adr = madr[cur]; exp_wd = mdat[cur];
        if (exp_we) mregs[exp_adr[1:0]] = exp_wd;
        else if (exp_adr[1:0] == 2'd0) begin exp_rd = exp_rx; exp_rx = exp_rx + 1; end
        else exp_rd = mregs[exp_adr[1:0]];
      end
    end
    m0_stb = 0; m1_stb = 0;
    repeat (10) step;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_contention;
    test_held_stb;
    test_stall;
    test_timeout;
    test_reset_mid_issue;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
